life_seq: RTL

Generation sequencer for the Life array. It turns decoded key presses into generation passes, either single-step or free-running at a frame-based rate. A generation pass holds `nxt_bit` high for exactly X*Y consecutive cycles so that the data shift ring and pipe advance one full generation. The block also issues `cell_flip` pulses for cursor edits, and only at points where the ring is not shifting.

---
 rtl/life_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/life_seq.sv
// Generation sequencer for the Life array: key events to shift passes and cell edits.
// Optional macro LIFE_GEN_CNT_EN builds the completed-generation counter; otherwise gen_cnt reads 0.
//
//   state | meaning
//   IDLE  | waiting for step / run key
//   SHIFT | nxt_bit high, ring advances one cell per cycle for X*Y cycles
//   HOLD  | run mode, counting frame ticks before the next pass
module life_seq #(
  parameter int X          = 8,
  parameter int Y          = 8,
  parameter int LOG2X      = 3,
  parameter int LOG2Y      = 3,
  parameter int RUN_FRAMES = 16,
  parameter int GEN_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       keys,
  input  logic             frame_tick,
  output logic             nxt_bit,
  output logic             cell_flip,
  output logic             running,
  output logic [GEN_W-1:0] gen_cnt
);

  localparam int              CW        = LOG2X + LOG2Y;
  localparam logic [CW-1:0]   CELL_LAST = CW'(X * Y - 1);
  localparam logic [7:0]      FR_FULL   = 8'(RUN_FRAMES);
  localparam logic [7:0]      FR_LAST   = 8'(RUN_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t        state_q;
  logic [2:0]    key_q;
  logic [CW-1:0] cell_q;
  logic [7:0]    frame_q;
  logic          flip_pend_q;
  logic          nxt_bit_q;
  logic          cell_flip_q;
  logic          running_q;

  logic flip_ev, step_ev, run_ev;
  logic pass_done, frame_full, run_next;

  assign flip_ev   = (keys == 3'd5) && (key_q != 3'd5);
  assign step_ev   = (keys == 3'd6) && (key_q != 3'd6);
  assign run_ev    = (keys == 3'd7) && (key_q != 3'd7);
  assign pass_done = (state_q == SHIFT) && (cell_q == CELL_LAST);
  assign run_next  = running_q ^ run_ev;
  // Saturated count lets a flip coinciding with the last tick go first; SHIFT follows next cycle.
  assign frame_full = (frame_q == FR_FULL) || (frame_tick && (frame_q == FR_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      key_q       <= 3'd0;
      cell_q      <= '0;
      frame_q     <= 8'd0;
      flip_pend_q <= 1'b0;
      nxt_bit_q   <= 1'b0;
      cell_flip_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      key_q       <= keys;
      cell_flip_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flip_ev) begin
            cell_flip_q <= 1'b1;
          end else if (step_ev) begin
            state_q   <= SHIFT;
            nxt_bit_q <= 1'b1;
          end else if (run_ev) begin
            running_q <= 1'b1;
            state_q   <= SHIFT;
            nxt_bit_q <= 1'b1;
          end
        end
        SHIFT: begin
          running_q <= run_next;
          if (pass_done) begin
            // Deferred edit lands on the first non-shifting cycle.
            cell_q      <= '0;
            nxt_bit_q   <= 1'b0;
            flip_pend_q <= 1'b0;
            cell_flip_q <= flip_pend_q | flip_ev;
            state_q     <= run_next ? HOLD : IDLE;
          end else begin
            cell_q <= cell_q + 1'b1;
            if (flip_ev) flip_pend_q <= 1'b1;
          end
        end
        HOLD: begin
          if (frame_tick && (frame_q != FR_FULL)) frame_q <= frame_q + 8'd1;
          if (run_ev) begin
            running_q <= 1'b0;
            frame_q   <= 8'd0;
            state_q   <= IDLE;
          end else if (flip_ev) begin
            cell_flip_q <= 1'b1;
          end else if (frame_full) begin
            frame_q   <= 8'd0;
            state_q   <= SHIFT;
            nxt_bit_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nxt_bit   = nxt_bit_q;
  assign cell_flip = cell_flip_q;
  assign running   = running_q;

`ifdef LIFE_GEN_CNT_EN
  logic [GEN_W-1:0] gen_q, gen_d;

  assign gen_d = gen_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          gen_q <= '0;
    else if (pass_done) gen_q <= gen_d;
  end

  assign gen_cnt = gen_q;
`else
  assign gen_cnt = '0;
`endif

endmodule
